memory_stage: RTL and testbench

//  MEM stage of the 5-stage RV32 pipeline: consumes the EX/MEM register (execute_pkg::ex_mem_t), performs

---
 rtl/execute_pkg.sv | 18 +
 rtl/memory_pkg.sv | 27 ++
 rtl/memory_stage_wait_timer.sv | 25 ++
 rtl/memory_stage.sv | 114 +++++++++++
 tb/tb_memory_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/execute_pkg.sv
// EX/MEM pipeline register layout shared by the execute and memory stages.
package execute_pkg;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    ex_ctrl_t    ctrl;
  } ex_mem_t;

endpackage

// File: rtl/memory_pkg.sv
// MEM/WB register layout, MEM stage state encoding and access legality helper.
package memory_pkg;
  import execute_pkg::*;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FAULT
  } mem_state_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // Only meaningful when the entry actually performs a memory access.
  function automatic logic access_illegal(input ex_mem_t e);
    return (e.ctrl.mem_read && e.ctrl.mem_write) || (e.alu_result[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Saturating wait counter for the MEM stage watchdog; expired once MAX_WAIT is reached.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);
  localparam int unsigned W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: word loads/stores over a ready/valid data port, stall generation,
// watchdog/alignment fault, and the registered MEM/WB output.
module memory_stage
  import execute_pkg::*;
  import memory_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  ex_mem_t     ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output mem_wb_t     mem_wb
);

  mem_state_t  state;
  mem_state_t  state_next;
  mem_wb_t     wb_next;
  logic        access;
  logic        complete;
  logic [31:0] load_data;
  logic        timer_inc;
  logic        timer_clr;
  logic        expired;

  assign dmem_we    = ex_mem.ctrl.mem_write;
  assign dmem_addr  = ex_mem.alu_result;
  assign dmem_wdata = ex_mem.rs2_data;
  assign access     = ex_mem.ctrl.mem_read | ex_mem.ctrl.mem_write;

  always_comb begin
    state_next = state;
    wb_next    = MEM_WB_BUBBLE;
    dmem_req   = 1'b0;
    mem_stall  = 1'b1;
    complete   = 1'b0;
    load_data  = '0;

    unique case (state)
      IDLE, REQ: begin
        if (!access) begin
          complete = 1'b1;
        end else if (access_illegal(ex_mem)) begin
          state_next = FAULT;
        end else begin
          dmem_req = 1'b1;
          if (ex_mem.ctrl.mem_write) begin
            if (dmem_ready) complete = 1'b1;
            else            state_next = REQ;
          end else if (dmem_ready && dmem_rvalid) begin
            complete  = 1'b1;
            load_data = dmem_rdata;
          end else begin
            state_next = dmem_ready ? RESP : REQ;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          complete  = 1'b1;
          load_data = dmem_rdata;
        end
      end
      FAULT: begin
      end
    endcase

    if (complete) begin
      mem_stall          = 1'b0;
      state_next         = IDLE;
      wb_next.alu_result = ex_mem.alu_result;
      wb_next.mem_data   = load_data;
      wb_next.rd         = ex_mem.rd;
      wb_next.reg_write  = ex_mem.ctrl.reg_write;
      wb_next.mem_to_reg = ex_mem.ctrl.mem_to_reg;
    end else if (state != FAULT && expired) begin
      state_next = FAULT;
    end
  end

  assign timer_inc = mem_stall && (state != FAULT);
  assign timer_clr = (state_next == IDLE);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .inc    (timer_inc),
    .clr    (timer_clr),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_fault <= 1'b0;
      mem_wb    <= MEM_WB_BUBBLE;
    end else begin
      state  <= state_next;
      mem_wb <= wb_next;
      if (state_next == FAULT) mem_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized transaction-level bench for memory_stage with a word-array memory model.
module tb_memory_stage;
  import execute_pkg::*;
  import memory_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int NEVER    = 1000;

  logic        clk = 1'b0;
  logic        reset;
  ex_mem_t     ex_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_fault;
  mem_wb_t     mem_wb;

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  memory_stage #(
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_mem     (ex_mem),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault),
    .mem_wb     (mem_wb)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    ex_mem      = '0;
    ex_mem.alu_result = $urandom;
    ex_mem.ctrl.mem_read = 1'b1;
    dmem_ready  = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset       = 1'b0;
    ex_mem      = '0;
    dmem_ready  = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = $urandom;
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_wb", mem_wb, 0);
    @(posedge clk);
    #1;
    check("rst_late_rvalid_wb", mem_wb, 0);
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (illegal)
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         input int ready_at, input int rvalid_at, input int abort_at);
    logic    is_load, is_store, illegal, accepted, complete, rdy, rv, fault_exp;
    logic [7:0] idx;
    int      cyc, stalls;
    mem_wb_t exp_wb;
    idx       = addr[9:2];
    is_load   = (kind == 1) || (kind == 3);
    is_store  = (kind == 2) || (kind == 3);
    illegal   = (kind == 3) || ((is_load || is_store) && addr[1:0] != 2'b00);
    accepted  = 1'b0;
    stalls    = 0;
    cyc       = 0;
    fault_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc == abort_at) return;
      ex_mem = '0;
      ex_mem.alu_result      = addr;
      ex_mem.rs2_data        = data;
      ex_mem.rd              = rd;
      ex_mem.ctrl.mem_read   = is_load;
      ex_mem.ctrl.mem_write  = is_store;
      ex_mem.ctrl.reg_write  = rw;
      ex_mem.ctrl.mem_to_reg = m2r;
      rdy = accepted ? 1'($urandom_range(0, 1)) : (cyc == ready_at);
      if (is_load && (accepted || cyc == ready_at)) rv = (cyc == rvalid_at);
      else                                          rv = 1'($urandom_range(0, 1));
      dmem_ready  = rdy;
      dmem_rvalid = rv;
      dmem_rdata  = (is_load && rv && cyc == rvalid_at) ? mem[idx] : $urandom;
      #1;
      if (illegal)       complete = 1'b0;
      else if (is_store) complete = rdy;
      else if (is_load)  complete = accepted ? rv : (rdy && rv);
      else               complete = 1'b1;
      check("req", dmem_req, !illegal && (is_load || is_store) && !accepted);
      check("stall", mem_stall, !complete);
      if (!illegal && (is_load || is_store) && !accepted) begin
        check("addr", dmem_addr, addr);
        check("we", dmem_we, is_store);
        if (is_store) check("wdata", dmem_wdata, data);
      end
      exp_wb = '0;
      if (complete) begin
        exp_wb.alu_result = addr;
        exp_wb.mem_data   = is_load ? mem[idx] : 32'h0;
        exp_wb.rd         = rd;
        exp_wb.reg_write  = rw;
        exp_wb.mem_to_reg = m2r;
        if (is_store) mem[idx] = data;
      end
      if (is_load && rdy) accepted = 1'b1;
      @(posedge clk);
      #1;
      check("mem_wb", mem_wb, exp_wb);
      if (!complete) stalls++;
      fault_exp = illegal || (stalls > MAX_WAIT);
      check("fault", mem_fault, fault_exp);
      if (complete || fault_exp) break;
      cyc++;
    end
    if (fault_exp) begin
      @(negedge clk);
      dmem_ready  = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      #1;
      check("fault_req", dmem_req, 0);
      check("fault_stall", mem_stall, 1);
      @(posedge clk);
      #1;
      check("fault_wb", mem_wb, 0);
      check("fault_sticky", mem_fault, 1);
      do_reset();
    end
  endtask

  initial begin
    int kind, sel, ra, va;
    logic [31:0] addr;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[64] = 32'hDEADBEEF;
    do_reset();

    run_txn(0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 0, 0, -1);
    run_txn(1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 0, 2, -1);
    run_txn(2, 32'h200, 32'h1234, 5'd0, 1'b0, 1'b0, 3, 0, -1);
    run_txn(1, 32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 0, 0, -1);
    run_txn(1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 0, NEVER, -1);
    run_txn(1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 0, NEVER, 1);
    do_reset();
    run_txn(1, 32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 0, 0, -1);

    for (int t = 0; t < 300; t++) begin
      sel  = int'($urandom_range(0, 31));
      kind = (sel < 10) ? 0 : (sel < 20) ? 1 : (sel < 30) ? 2 : 3;
      addr = {22'($urandom), 8'($urandom), 2'b00};
      if ($urandom_range(0, 31) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      ra = int'($urandom_range(0, 4));
      va = ra + int'($urandom_range(0, 4));
      if ($urandom_range(0, 47) == 0) begin
        if ($urandom_range(0, 1) == 0) ra = NEVER;
        va = NEVER;
      end
      run_txn(kind, addr, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ra, va, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
